mlp_hls_deadlock_report_unit: RTL
=================================

# mlp_hls_deadlock_report_unit

Central collector downstream of the per-process deadlock detect units of the MLP HLS dataflow region. It takes every unit's `dl_detect_out` and each process's token-arrival indication. On a deadlock it:
- elects one origin process and injects the token walk;
- traces the dependency cycle as the token returns;
- clears the tokens;
- presents a latched report on a valid/ready port.

It also drives the sticky global deadlock flag that is fed back as `dl_detect_in` to all detect units.

## Interface
Parameters:
- `PROC_NUM`, 4, number of dataflow processes / detect units
- `ID_W`, 2, process-index width; must equal max(1, ceil(log2(PROC_NUM)))
- `HOP_W`, 8, hop-counter width
- `TRACE_TIMEOUT`, 64, maximum TRACE cycles before abort (1..2^16-1)

Ports:
- `clock`  in  1  clock
- `reset`  in  1  reset, asynchronous, active-low
- `dl_detect_in_vec`  in  PROC_NUM  bit i = `dl_detect_out` of detect unit i
- `token_vld_vec`  in  PROC_NUM  bit i = OR of unit i's `token_in_vec` (token present at process i)
- `dl_clear`  in  1  re-arm request from host/debug logic
- `dl_detect_out`  out  1  sticky global deadlock flag, broadcast to all units' `dl_detect_in`
- `origin`  out  PROC_NUM  one-hot, bit i to unit i's `origin`
- `token_clear`  out  1  broadcast to all units' `token_clear`
- `rpt_valid`  out  1  report available
- `rpt_ready`  in  1  report consumer ready
- `rpt_origin_id`  out  ID_W  index of elected origin
- `rpt_cycle_mask`  out  PROC_NUM  processes the token visited
- `rpt_hops`  out  HOP_W  number of token-carrying cycles before return (saturating)
- `rpt_timeout`  out  1  trace aborted by timeout
- `rpt_path`  out  PROC_NUM*ID_W  visit order, entry k at bits [k*ID_W +: ID_W] (only with `MLP_HLS_DL_TRACE_EN`)

## Operation
FSM states and transitions:
- **IDLE**
  - All outputs 0.
  - When `|dl_detect_in_vec`, register origin_id = lowest set index.
  - Clear mask, hops, timer and path, then go to ARM.
- **ARM** (one cycle)
  - `origin` = one-hot(origin_id); `dl_detect_out` = 1 from this state onward.
  - Next state is TRACE.
- **TRACE**
  - Timer increments each cycle.
  - **Return:** when `token_vld_vec[origin_id]`=1 and hops≥1:
    - set the origin bit in mask;
    - assert `token_clear` combinationally this cycle;
    - go to REPORT with rpt_timeout=0.
  - **Token seen (not a return):** otherwise, if `token_vld_vec` is non-zero:
    - OR `token_vld_vec` into mask;
    - when hops<PROC_NUM, record the lowest set index as path[hops];
    - increment hops, saturating at 2^HOP_W-1.
  - **Timeout:** if the timer reaches TRACE_TIMEOUT-1 without a return:
    - assert `token_clear` this cycle;
    - set rpt_timeout=1;
    - go to REPORT.
- **REPORT**
  - `rpt_valid`=1. All `rpt_*` fields are registered and stable while valid.
  - On `rpt_valid & rpt_ready`, go to HOLD.
- **HOLD**
  - `dl_detect_out` stays 1; `rpt_valid`=0.
  - `dl_clear`=1 returns the FSM to IDLE and drops `dl_detect_out` the next cycle.

Rules:
- `dl_detect_in_vec` is ignored outside IDLE. Simultaneous detects elect the lowest index.
- Multiple simultaneous tokens (branching) are all added to the mask; the path records the lowest index only.
- `dl_clear` outside HOLD has no effect.
- The origin token bit observed in ARM (hops=0) is not treated as a return.

## Timing
- Reset is asynchronous. On `reset`=0: state=IDLE, every output 0, all internal registers 0, regardless of current state (including mid-TRACE).
- Detect in cycle N →
  - ARM in N+1 (`origin` and `dl_detect_out` high);
  - TRACE from N+2.
- `token_clear` is high for exactly one cycle: the cycle the return or timeout is seen. `rpt_valid` rises the next cycle.
- `rpt_valid` holds until the handshake; one report per detection.
- All outputs are registered except `token_clear`.

## Configuration
- `MLP_HLS_DL_TRACE_EN` defined:
  - the path register file and `rpt_path` port exist;
  - unwritten entries read 0.
- Not defined:
  - the `rpt_path` port and path storage are absent;
  - all other behaviour is identical.

## Test plan
All cases use PROC_NUM=4, TRACE_TIMEOUT=64.
- **Basic walk.**
  - Stimulus: `dl_detect_in_vec`=4'b0100 in cycle 0; tokens at process 3 in cycle 3, process 0 in cycle 4, process 2 in cycle 5.
  - Required: `origin`=4'b0100 in cycle 1 only; `token_clear`=1 in cycle 5 only.
  - Report: origin_id=2, mask=4'b1101, hops=2, timeout=0, path[0]=3, path[1]=0.
- **Simultaneous detects.** `dl_detect_in_vec`=4'b1010 → `origin`=4'b0010, rpt_origin_id=1.
- **Timeout.**
  - Stimulus: detect on process 0; no tokens for 64 TRACE cycles.
  - Required: `token_clear` pulses on the 64th TRACE cycle; report has timeout=1, mask=0, hops=0.
- **Backpressure.**
  - Stimulus: `rpt_ready`=0 for 5 cycles after `rpt_valid` rises, then 1.
  - Required: fields stable across those cycles; exactly one handshake; `dl_detect_out` stays 1 in HOLD.
- **Re-arm.** `dl_clear` in HOLD → `dl_detect_out`=0 the next cycle; a new detect is then accepted. Detects raised during HOLD produce no report.
- **Reset mid-trace.** `reset` asserted in TRACE → all outputs 0 immediately; after release, the FSM stays in IDLE with no `token_clear`.

Source files
------------

// File: rtl/mlp_hls_deadlock_report_unit.sv
// mlp_hls_deadlock_report_unit
//   Central deadlock collector for the MLP HLS dataflow region. It watches
//   every detect unit's dl_detect_out and elects the lowest-indexed reporting
//   process as origin. It injects the token walk from that origin and traces
//   which processes the token visits until it returns, or until a timeout.
//   It then clears the tokens and presents a latched report on a
//   valid/ready port. The sticky global deadlock flag is fed back to all
//   detect units.
//
//   Optional feature macro: MLP_HLS_DL_TRACE_EN
//     When defined, the visit order is recorded in a small path register file
//     and exposed on rpt_path. When not defined, the port and storage are
//     absent.
//
// Ports
//   clock, reset                 clock, async active-low reset
//   dl_detect_in_vec [PROC_NUM]  per-unit deadlock detect
//   token_vld_vec    [PROC_NUM]  token present at process i
//   dl_clear                     re-arm request (honoured only in HOLD)
//   dl_detect_out                sticky global deadlock flag
//   origin           [PROC_NUM]  one-hot origin strobe (ARM cycle only)
//   token_clear                  combinational, one cycle on return/timeout
//   rpt_valid / rpt_ready        report handshake
//   rpt_origin_id    [ID_W]      elected origin index
//   rpt_cycle_mask   [PROC_NUM]  processes visited by the token
//   rpt_hops         [HOP_W]     token-carrying cycles before return (sat.)
//   rpt_timeout                  trace aborted by timeout
//   rpt_path  [PROC_NUM*ID_W]    visit order (MLP_HLS_DL_TRACE_EN only)

module mlp_hls_deadlock_report_unit #(
    parameter int PROC_NUM      = 4,
    parameter int ID_W          = 2,
    parameter int HOP_W         = 8,
    parameter int TRACE_TIMEOUT = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [PROC_NUM-1:0]      dl_detect_in_vec,
    input  logic [PROC_NUM-1:0]      token_vld_vec,
    input  logic                     dl_clear,
    output logic                     dl_detect_out,
    output logic [PROC_NUM-1:0]      origin,
    output logic                     token_clear,
    output logic                     rpt_valid,
    input  logic                     rpt_ready,
    output logic [ID_W-1:0]          rpt_origin_id,
    output logic [PROC_NUM-1:0]      rpt_cycle_mask,
    output logic [HOP_W-1:0]         rpt_hops,
    output logic                     rpt_timeout
`ifdef MLP_HLS_DL_TRACE_EN
    ,
    output logic [PROC_NUM*ID_W-1:0] rpt_path
`endif
);

    localparam int TMR_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_TRACE,
        S_REPORT,
        S_HOLD
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     origin_id;
    logic [PROC_NUM-1:0] mask, mask_nxt;
    logic [HOP_W-1:0]    hops, hops_nxt;
    logic [TMR_W-1:0]    timer;
    logic                ret, seen, tmo;

    // Lowest set index of a vector; 0 when empty.
    function automatic logic [ID_W-1:0] lowest(input logic [PROC_NUM-1:0] v);
        lowest = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--)
            if (v[i]) lowest = ID_W'(i);
    endfunction

    function automatic logic [PROC_NUM-1:0] onehot(input logic [ID_W-1:0] id);
        onehot = PROC_NUM'(1) << id;
    endfunction

`ifdef MLP_HLS_DL_TRACE_EN
    logic [PROC_NUM-1:0][ID_W-1:0] path;
    assign rpt_path = path;
`endif

    // The origin's own token only counts as a return once the walk has
    // carried the token at least once; the injection itself is not a return.
    always_comb begin
        ret      = (state == S_TRACE) && token_vld_vec[origin_id] && (hops != '0);
        seen     = (state == S_TRACE) && !ret && (|token_vld_vec);
        tmo      = (state == S_TRACE) && !ret && (timer == TMR_W'(TRACE_TIMEOUT - 1));
        mask_nxt = mask;
        hops_nxt = hops;
        if (ret) begin
            mask_nxt = mask | onehot(origin_id);
        end else if (seen) begin
            mask_nxt = mask | token_vld_vec;
            hops_nxt = (hops == '1) ? hops : hops + 1'b1;
        end
        token_clear = ret | tmo;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            origin_id      <= '0;
            mask           <= '0;
            hops           <= '0;
            timer          <= '0;
            dl_detect_out  <= 1'b0;
            origin         <= '0;
            rpt_valid      <= 1'b0;
            rpt_origin_id  <= '0;
            rpt_cycle_mask <= '0;
            rpt_hops       <= '0;
            rpt_timeout    <= 1'b0;
`ifdef MLP_HLS_DL_TRACE_EN
            path           <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (|dl_detect_in_vec) begin
                        origin_id     <= lowest(dl_detect_in_vec);
                        origin        <= onehot(lowest(dl_detect_in_vec));
                        dl_detect_out <= 1'b1;
                        mask          <= '0;
                        hops          <= '0;
                        timer         <= '0;
`ifdef MLP_HLS_DL_TRACE_EN
                        path          <= '0;
`endif
                        state         <= S_ARM;
                    end
                end
                S_ARM: begin
                    origin <= '0;
                    state  <= S_TRACE;
                end
                S_TRACE: begin
                    timer <= timer + 1'b1;
                    mask  <= mask_nxt;
                    hops  <= hops_nxt;
`ifdef MLP_HLS_DL_TRACE_EN
                    if (seen && (32'(hops) < PROC_NUM))
                        path[hops[ID_W-1:0]] <= lowest(token_vld_vec);
`endif
                    if (ret || tmo) begin
                        rpt_valid      <= 1'b1;
                        rpt_origin_id  <= origin_id;
                        rpt_cycle_mask <= mask_nxt;
                        rpt_hops       <= hops_nxt;
                        rpt_timeout    <= tmo;
                        state          <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid <= 1'b0;
                        state     <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    // Back to a fully quiet IDLE: every output and register zero.
                    if (dl_clear) begin
                        origin_id      <= '0;
                        mask           <= '0;
                        hops           <= '0;
                        timer          <= '0;
                        dl_detect_out  <= 1'b0;
                        rpt_origin_id  <= '0;
                        rpt_cycle_mask <= '0;
                        rpt_hops       <= '0;
                        rpt_timeout    <= 1'b0;
`ifdef MLP_HLS_DL_TRACE_EN
                        path           <= '0;
`endif
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
